// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 byte driver: command bytes, init ROM and FSM states.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] ENTRY_INC     = 8'h06;
  localparam logic [7:0] SET_DDRAM     = 8'h80;
  localparam logic [7:0] HOME          = 8'h02;

  localparam int unsigned INIT_LEN = 5;

  typedef enum logic [2:0] {
    StPwrWait,
    StInitLoad,
    StSetup,
    StPulse,
    StHold,
    StExec,
    StIdle
  } lcd_state_e;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    unique case (idx)
      3'd0:    init_rom = FUNC_SET_8B2L;
      3'd1:    init_rom = DISP_ON;
      3'd2:    init_rom = CLEAR;
      3'd3:    init_rom = ENTRY_INC;
      default: init_rom = SET_DDRAM;
    endcase
  endfunction

  // Timer reload value for a phase of `cycles` length; zero-length phases still take one cycle.
  function automatic int unsigned phase_ld(input int unsigned cycles);
    phase_ld = (cycles == 0) ? 0 : cycles - 1;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every LCD timing phase; saturates at zero.
module lcd_timer
  import lcd_pkg::*;
#(
  parameter int unsigned CNT_W   = 20,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_count,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= CNT_W'(RST_VAL);
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/lcd_bus_ctrl.sv
// HD44780 byte driver: runs the power-up init sequence, then writes handshaked bytes
// with setup/pulse/hold strobe timing and the controller's execution delay.
module lcd_bus_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned PWRUP_CYCLES    = 750000,
  parameter int unsigned SETUP_CYCLES    = 4,
  parameter int unsigned PULSE_CYCLES    = 16,
  parameter int unsigned HOLD_CYCLES     = 4,
  parameter int unsigned WAIT_CYCLES     = 2500,
  parameter int unsigned CLR_WAIT_CYCLES = 82000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       iCLK_50MHZ,
  input  logic       iRST_N,
  input  logic       iVALID,
  input  logic       iRS,
  input  logic [7:0] iDATA,
  output logic       oREADY,
  output logic       oINIT_DONE,
  output logic [7:0] DATA_BUS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic       LCD_RS
);

  lcd_state_e       r_state, w_state_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_init_done, w_init_done_nxt;
  logic             r_e, w_e_nxt;
  logic             r_rs, w_rs_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_t_done;
  logic             w_slow;

  lcd_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(phase_ld(PWRUP_CYCLES))
  ) u_timer (
    .i_clk     (iCLK_50MHZ),
    .i_rst_n   (iRST_N),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .i_count   (1'b1),
    .o_done    (w_t_done)
  );

  // Clear and return-home (0x01..0x03) need the long execution wait.
  assign w_slow = !r_rs && (r_data[7:2] == 6'b0);

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= StPwrWait;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_e         <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_idx       <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= w_ready_nxt;
      r_init_done <= w_init_done_nxt;
      r_e         <= w_e_nxt;
      r_rs        <= w_rs_nxt;
      r_data      <= w_data_nxt;
      r_idx       <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ready_nxt     = r_ready;
    w_init_done_nxt = r_init_done;
    w_e_nxt         = r_e;
    w_rs_nxt        = r_rs;
    w_data_nxt      = r_data;
    w_idx_nxt       = r_idx;
    w_load          = 1'b0;
    w_load_val      = '0;
    unique case (r_state)
      StPwrWait: begin
        if (w_t_done) w_state_nxt = StInitLoad;
      end
      StInitLoad: begin
        w_data_nxt  = init_rom(r_idx);
        w_rs_nxt    = 1'b0;
        w_state_nxt = StSetup;
        w_load      = 1'b1;
        w_load_val  = CNT_W'(phase_ld(SETUP_CYCLES));
      end
      StSetup: begin
        if (w_t_done) begin
          w_state_nxt = StPulse;
          w_e_nxt     = 1'b1;
          w_load      = 1'b1;
          w_load_val  = CNT_W'(phase_ld(PULSE_CYCLES));
        end
      end
      StPulse: begin
        if (w_t_done) begin
          w_state_nxt = StHold;
          w_e_nxt     = 1'b0;
          w_load      = 1'b1;
          w_load_val  = CNT_W'(phase_ld(HOLD_CYCLES));
        end
      end
      StHold: begin
        if (w_t_done) begin
          w_state_nxt = StExec;
          w_load      = 1'b1;
          w_load_val  = w_slow ? CNT_W'(phase_ld(CLR_WAIT_CYCLES))
                               : CNT_W'(phase_ld(WAIT_CYCLES));
        end
      end
      StExec: begin
        if (w_t_done) begin
          if (!r_init_done && (r_idx != 3'(INIT_LEN - 1))) begin
            w_idx_nxt   = r_idx + 3'd1;
            w_state_nxt = StInitLoad;
          end else begin
            w_init_done_nxt = 1'b1;
            w_ready_nxt     = 1'b1;
            w_state_nxt     = StIdle;
          end
        end
      end
      StIdle: begin
        if (iVALID && r_ready) begin
          w_rs_nxt    = iRS;
          w_data_nxt  = iDATA;
          w_ready_nxt = 1'b0;
          w_state_nxt = StSetup;
          w_load      = 1'b1;
          w_load_val  = CNT_W'(phase_ld(SETUP_CYCLES));
        end
      end
      default: w_state_nxt = StPwrWait;
    endcase
  end

  assign oREADY     = r_ready;
  assign oINIT_DONE = r_init_done;
  assign DATA_BUS   = r_data;
  assign LCD_RS     = r_rs;
  assign LCD_E      = r_e;
  assign LCD_RW     = 1'b0;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Directed bench for lcd_bus_ctrl with shortened timing (S=2 P=4 H=2 W=5 CLR=30 PWRUP=20).
module tb_lcd_bus_ctrl;

  logic       iCLK_50MHZ = 1'b0;
  logic       iRST_N = 1'b0;
  logic       iVALID = 1'b0;
  logic       iRS = 1'b0;
  logic [7:0] iDATA = 8'h00;
  logic       oREADY, oINIT_DONE, LCD_RW, LCD_E, LCD_RS;
  logic [7:0] DATA_BUS;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_bus_ctrl #(
    .PWRUP_CYCLES   (20),
    .SETUP_CYCLES   (2),
    .PULSE_CYCLES   (4),
    .HOLD_CYCLES    (2),
    .WAIT_CYCLES    (5),
    .CLR_WAIT_CYCLES(30),
    .CNT_W          (20)
  ) dut (
    .iCLK_50MHZ(iCLK_50MHZ),
    .iRST_N    (iRST_N),
    .iVALID    (iVALID),
    .iRS       (iRS),
    .iDATA     (iDATA),
    .oREADY    (oREADY),
    .oINIT_DONE(oINIT_DONE),
    .DATA_BUS  (DATA_BUS),
    .LCD_RW    (LCD_RW),
    .LCD_E     (LCD_E),
    .LCD_RS    (LCD_RS)
  );

  always #10 iCLK_50MHZ = ~iCLK_50MHZ;

  task automatic tick();
    @(posedge iCLK_50MHZ);
    #1;
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({oREADY, oINIT_DONE, DATA_BUS, LCD_E, LCD_RS, LCD_RW} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b done=%b data=%h e=%b rs=%b rw=%b, want all 0",
               oREADY, oINIT_DONE, DATA_BUS, LCD_E, LCD_RS, LCD_RW);
    end
  endtask

  // Releases reset and checks the full init sequence; cycle n = n-th rising edge after release.
  task automatic test_init(input string tag);
    logic [7:0] exp_data [5] = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
    int         exp_rise [5] = '{23, 37, 51, 90, 104};
    int         nr = 0;
    logic       prev_e = 1'b0;
    @(negedge iCLK_50MHZ);
    iRST_N = 1'b1;
    for (int n = 1; n <= 125; n++) begin
      tick();
      if (LCD_E && !prev_e) begin
        n_checks++;
        if (nr >= 5) begin
          n_fail++;
          $display("FAIL %s_extra_pulse: got E rise at cycle %0d, want only 5 pulses", tag, n);
        end else if (n != exp_rise[nr] || DATA_BUS !== exp_data[nr] || LCD_RS !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_pulse%0d: got cycle=%0d data=%h rs=%b, want cycle=%0d data=%h rs=0",
                   tag, nr, n, DATA_BUS, LCD_RS, exp_rise[nr], exp_data[nr]);
        end
        nr++;
      end
      prev_e = LCD_E;
      if (n < 115 && (oREADY || oINIT_DONE)) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_early_ready: got rdy=%b done=%b at cycle %0d, want 0 before 115",
                 tag, oREADY, oINIT_DONE, n);
      end
      if (n == 115) begin
        n_checks++;
        if (oREADY !== 1'b1 || oINIT_DONE !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_init_done: got rdy=%b done=%b at cycle 115, want 1 1",
                   tag, oREADY, oINIT_DONE);
        end
        iVALID = 1'b0;
      end
    end
    n_checks++;
    if (nr != 5) begin
      n_fail++;
      $display("FAIL %s_pulse_count: got %0d, want 5", tag, nr);
    end
  endtask

  task automatic test_single_char();
    iVALID = 1'b1; iRS = 1'b1; iDATA = 8'h41;
    tick();
    iVALID = 1'b0;
    n_checks++;
    if (LCD_RS !== 1'b1 || DATA_BUS !== 8'h41 || oREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL char_accept: got rs=%b data=%h rdy=%b, want 1 41 0", LCD_RS, DATA_BUS, oREADY);
    end
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 3) begin
        iDATA = 8'h5A; iRS = 1'b0;
      end
      n_checks++;
      if (LCD_E !== (k >= 2 && k <= 5) || oREADY !== (k == 13) || DATA_BUS !== 8'h41
          || LCD_RS !== 1'b1) begin
        n_fail++;
        $display("FAIL char_t%0d: got e=%b rdy=%b data=%h rs=%b, want e=%b rdy=%b data=41 rs=1",
                 k, LCD_E, oREADY, DATA_BUS, LCD_RS, (k >= 2 && k <= 5), (k == 13));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3] = '{8'h48, 8'h49, 8'h21};
    iVALID = 1'b1; iRS = 1'b1; iDATA = bytes[0];
    tick();
    n_checks++;
    if (DATA_BUS !== 8'h48) begin
      n_fail++;
      $display("FAIL b2b_first: got data=%h, want 48", DATA_BUS);
    end
    for (int b = 0; b < 3; b++) begin
      if (b < 2) iDATA = bytes[b+1];
      else iVALID = 1'b0;
      for (int k = 1; k <= 13; k++) begin
        tick();
        n_checks++;
        if (DATA_BUS !== bytes[b] || oREADY !== (k == 13)) begin
          n_fail++;
          $display("FAIL b2b_byte%0d_t%0d: got data=%h rdy=%b, want data=%h rdy=%b",
                   b, k, DATA_BUS, oREADY, bytes[b], (k == 13));
        end
      end
      if (b < 2) begin
        tick();
        n_checks++;
        if (DATA_BUS !== bytes[b+1] || oREADY !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_accept%0d: got data=%h rdy=%b, want data=%h rdy=0",
                   b + 1, DATA_BUS, oREADY, bytes[b+1]);
        end
      end
    end
  endtask

  task automatic test_slow_cmd();
    logic [7:0] cmds [2] = '{8'h01, 8'h80};
    int         lat  [2] = '{38, 13};
    for (int c = 0; c < 2; c++) begin
      iVALID = 1'b1; iRS = 1'b0; iDATA = cmds[c];
      tick();
      iVALID = 1'b0;
      for (int k = 1; k <= lat[c]; k++) begin
        tick();
        if (oREADY || k == lat[c]) begin
          n_checks++;
          if (oREADY !== (k == lat[c])) begin
            n_fail++;
            $display("FAIL cmd_%h_ready: got rdy=%b at t0+%0d, want rdy first at t0+%0d",
                     cmds[c], oREADY, k, lat[c]);
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    iVALID = 1'b1; iRS = 1'b1; iDATA = 8'h33;
    tick();
    iVALID = 1'b0;
    tick();
    tick();
    n_checks++;
    if (LCD_E !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre_e: got e=%b, want 1", LCD_E);
    end
    #3;
    iRST_N = 1'b0;
    #1;
    n_checks++;
    if (LCD_E !== 1'b0 || oINIT_DONE !== 1'b0 || oREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_async: got e=%b done=%b rdy=%b, want 0 0 0", LCD_E, oINIT_DONE, oREADY);
    end
    // Hold a request during the whole re-init; it must be ignored.
    iVALID = 1'b1; iRS = 1'b1; iDATA = 8'hFF;
    tick();
    test_init("reinit");
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_single_char();
    test_back_to_back();
    test_slow_cmd();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
